// File: rtl/flop_r.sv
// ============================================================================
// Module   : flop_r
// Brief    : N-bit D register with synchronous, active-high reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flop_r #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] data_d;
  logic [N-1:0] data_q;

  // Reset takes priority over d at the same edge.
  always_comb begin
    data_d = d;
    if (reset) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

`default_nettype wire

// File: tb/tb_flop_r.sv
// ============================================================================
// Module   : tb_flop_r
// Brief    : Self-checking bench for flop_r at N=64, N=8 and N=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flop_r;

  logic        clk;
  logic        reset;
  logic [63:0] d64;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic [63:0] q64;
  logic [7:0]  q8;
  logic [0:0]  q1;

  int total;
  int bad;

  flop_r #(.N(64)) u_dut64 (.clk(clk), .reset(reset), .d(d64), .q(q64));
  flop_r #(.N(8))  u_dut8  (.clk(clk), .reset(reset), .d(d8),  .q(q8));
  flop_r #(.N(1))  u_dut1  (.clk(clk), .reset(reset), .d(d1),  .q(q1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [63:0] d;
    logic [63:0] exp;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Compare all three widths against one full-width expected value.
  task automatic chk_all(input string nm, input logic [63:0] exp);
    chk({nm, "/N64"}, q64, exp);
    chk({nm, "/N8"},  {56'd0, q8}, {56'd0, exp[7:0]});
    chk({nm, "/N1"},  {63'd0, q1}, {63'd0, exp[0]});
  endtask

  task automatic drive(input logic rst, input logic [63:0] dv);
    reset = rst;
    d64   = dv;
    d8    = dv[7:0];
    d1    = dv[0];
  endtask

  logic        last_rst;
  logic [63:0] last_d;
  logic [63:0] model_q;
  logic [63:0] prev_exp;

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 64'd0);

    // T1 .. T4
    tv[0]  = '{1'b1, 64'd10,      64'd0};
    tv[1]  = '{1'b1, 64'd21,      64'd0};
    tv[2]  = '{1'b1, 64'd41,      64'd0};
    tv[3]  = '{1'b1, 64'd44,      64'd0};
    tv[4]  = '{1'b1, 64'd151375,  64'd0};
    tv[5]  = '{1'b0, 64'd999999,  64'd999999};
    tv[6]  = '{1'b0, 64'd31,      64'd31};
    tv[7]  = '{1'b0, 64'd0,       64'd0};
    tv[8]  = '{1'b0, 64'd124124124, 64'd124124124};
    tv[9]  = '{1'b0, 64'd12121212,  64'd12121212};
    tv[10] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[11] = '{1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5};

    prev_exp = 64'd0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      drive(tv[i].rst, tv[i].d);
      @(negedge clk);
      // Before the capturing edge q must still show the previous value.
      if (i > 0) chk_all($sformatf("pre%0d", i), prev_exp);
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tv[i].exp);
      prev_exp = tv[i].exp;
    end

    // T5: reset asserted and released between edges.
    @(posedge clk);
    #1;
    drive(1'b0, 64'd12121212);
    @(posedge clk);
    @(negedge clk);
    chk_all("t5_load", 64'd12121212);
    reset = 1'b1;
    #1;
    chk_all("t5_rst_async", 64'd12121212);
    @(posedge clk);
    @(negedge clk);
    chk_all("t5_rst_edge", 64'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 64'd7);
    #1;
    chk_all("t5_rel_async", 64'd0);
    @(negedge clk);
    chk_all("t5_rel_pre", 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all("t5_rel_edge", 64'd7);

    // Randomized phase against a one-cycle-delay model.
    @(posedge clk);
    #1;
    drive(1'b1, {$urandom, $urandom});
    last_rst = reset;
    last_d   = d64;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      model_q = last_rst ? 64'd0 : last_d;
      #1;
      drive(($urandom_range(0, 9) == 0), {$urandom, $urandom});
      last_rst = reset;
      last_d   = d64;
      @(negedge clk);
      chk_all($sformatf("rnd%0d", k), model_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
